// File: rtl/cle_pkg.sv
// Shared types for the connected-component labeller: FSM states and the
// neighbour label-select helper (min/max of the nonzero neighbour labels).
package cle_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    WR,
    RL_RD,
    RL_CMP,
    RL_WR,
    DONE
  } state_t;

  // Widest label the helper handles; instances zero-extend into it.
  localparam int LBL_MAX_W = 16;

  typedef logic [LBL_MAX_W-1:0] lbl_t;

  typedef struct packed {
    lbl_t a;    // smallest nonzero neighbour label
    lbl_t b;    // largest nonzero neighbour label
    logic any;  // at least one neighbour is labelled
  } lbl_sel_t;

  function automatic lbl_sel_t sel_labels(input lbl_t n0, input lbl_t n1,
                                          input lbl_t n2, input lbl_t n3);
    lbl_sel_t s;
    lbl_t     v [4];
    // NOTE: blocking assignments are right here: this is combinational
    // scratch evaluated in order, not clocked state.
    v[0] = n0;
    v[1] = n1;
    v[2] = n2;
    v[3] = n3;
    s    = '0;
    for (int i = 0; i < 4; i++) begin
      if (v[i] != '0) begin
        if (!s.any) begin
          s.a   = v[i];
          s.b   = v[i];
          s.any = 1'b1;
        end else begin
          if (v[i] < s.a) s.a = v[i];
          if (v[i] > s.b) s.b = v[i];
        end
      end
    end
    return s;
  endfunction

endpackage

// File: rtl/cle_param_nbr_win.sv
// Neighbour window: holds L/UL/U labels, masks neighbours outside the image
// or across a row wrap, and derives the A/B labels and the merge condition.
module cle_nbr_win
  import cle_pkg::*;
#(
  parameter  int W_LOG2  = 5,
  parameter  int H_LOG2  = 5,
  parameter  int LABEL_W = 8,
  localparam int AW      = W_LOG2 + H_LOG2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_shift,
  input  logic               i_subst,
  input  logic               i_conn8,
  input  logic [AW-1:0]      i_p,
  input  logic [LABEL_W-1:0] i_new_lbl,
  input  logic [LABEL_W-1:0] i_ur,
  input  logic [LABEL_W-1:0] i_sub_a,
  input  logic [LABEL_W-1:0] i_sub_b,
  output logic [LABEL_W-1:0] o_a,
  output logic [LABEL_W-1:0] o_b,
  output logic               o_any,
  output logic               o_conflict
);

  logic [LABEL_W-1:0] r_l, r_ul, r_u;
  logic [LABEL_W-1:0] w_l, w_ul, w_u, w_ur;
  logic [W_LOG2-1:0]  w_col;
  logic [H_LOG2-1:0]  w_row;
  logic               w_col_first, w_col_last, w_row_first;
  lbl_sel_t           w_sel;

  assign w_col       = i_p[W_LOG2-1:0];
  assign w_row       = i_p[AW-1:W_LOG2];
  assign w_col_first = (w_col == '0);
  assign w_col_last  = &w_col;
  assign w_row_first = (w_row == '0);

  // Registers shift raw values; validity is decided at the pixel that uses them.
  assign w_l  = w_col_first ? '0 : r_l;
  assign w_u  = w_row_first ? '0 : r_u;
  assign w_ul = (w_col_first || w_row_first || !i_conn8) ? '0 : r_ul;
  assign w_ur = (w_col_last  || w_row_first || !i_conn8) ? '0 : i_ur;

  assign w_sel      = sel_labels(LBL_MAX_W'(w_l), LBL_MAX_W'(w_ul),
                                 LBL_MAX_W'(w_u), LBL_MAX_W'(w_ur));
  assign o_a        = w_sel.a[LABEL_W-1:0];
  assign o_b        = w_sel.b[LABEL_W-1:0];
  assign o_any      = w_sel.any;
  assign o_conflict = w_sel.any && (w_sel.a != w_sel.b);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_l  <= '0;
      r_ul <= '0;
      r_u  <= '0;
    end else if (i_shift) begin
      r_l  <= i_new_lbl;
      r_ul <= r_u;
      r_u  <= i_ur;
    end else if (i_subst) begin
      if (r_l  == i_sub_b) r_l  <= i_sub_a;
      if (r_ul == i_sub_b) r_ul <= i_sub_a;
      if (r_u  == i_sub_b) r_u  <= i_sub_a;
    end
  end

endmodule

// File: rtl/cle_param.sv
// Raster-scan connected-component labeller with in-place backward relabel,
// selectable 4/8-connectivity and a sticky label-overflow flag.
module cle_param
  import cle_pkg::*;
#(
  parameter  int W_LOG2  = 5,
  parameter  int H_LOG2  = 5,
  parameter  int LABEL_W = 8,
  localparam int AW      = W_LOG2 + H_LOG2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               conn8,
  output logic [AW-4:0]      rom_a,
  input  logic [7:0]         rom_q,
  output logic [AW-1:0]      sram_a,
  output logic [LABEL_W-1:0] sram_d,
  output logic               sram_wen,
  input  logic [LABEL_W-1:0] sram_q,
  output logic               busy,
  output logic               finish,
  output logic [LABEL_W-1:0] label_count,
  output logic               overflow
);

  localparam logic [AW-1:0]      LAST_P  = '1;
  localparam logic [AW-1:0]      UR_OFF  = AW'((1 << W_LOG2) - 1);
  localparam logic [LABEL_W-1:0] LBL_SAT = '1;

  state_t             r_state;
  logic [AW-1:0]      r_p, r_rl_a;
  logic [LABEL_W-1:0] r_a, r_b, r_label_count;
  logic               r_conn8, r_overflow, r_busy, r_finish;

  logic [LABEL_W-1:0] w_a, w_b, w_label;
  logic               w_any, w_conflict, w_pix, w_merge, w_pass_end, w_advance;

  assign w_pix      = rom_q[~r_p[2:0]];
  assign w_merge    = w_pix && w_conflict;
  assign w_pass_end = (r_rl_a == '0) &&
                      ((r_state == RL_CMP && sram_q != r_b) || r_state == RL_WR);
  assign w_advance  = (r_state == WR && !w_merge) || w_pass_end;

  cle_nbr_win #(
    .W_LOG2 (W_LOG2),
    .H_LOG2 (H_LOG2),
    .LABEL_W(LABEL_W)
  ) u_nbr (
    .clk       (clk),
    .reset     (reset),
    .i_shift   (r_state == WR),
    .i_subst   (w_pass_end),
    .i_conn8   (r_conn8),
    .i_p       (r_p),
    .i_new_lbl (w_label),
    .i_ur      (sram_q),
    .i_sub_a   (r_a),
    .i_sub_b   (r_b),
    .o_a       (w_a),
    .o_b       (w_b),
    .o_any     (w_any),
    .o_conflict(w_conflict)
  );

  always_comb begin
    w_label = '0;
    if (w_pix) begin
      if (w_any)                          w_label = w_a;
      else if (r_label_count == LBL_SAT)  w_label = LBL_SAT;
      else                                w_label = r_label_count + LABEL_W'(1);
    end
  end

  // NOTE: defaults first so every path drives every output; no latches.
  always_comb begin
    rom_a    = '0;
    sram_a   = '0;
    sram_d   = '0;
    sram_wen = 1'b1;
    case (r_state)
      RD: begin
        rom_a  = r_p[AW-1:3];
        sram_a = r_p - UR_OFF;
      end
      WR: begin
        sram_a   = r_p;
        sram_d   = w_label;
        sram_wen = 1'b0;
      end
      RL_RD, RL_CMP: sram_a = r_rl_a;
      RL_WR: begin
        sram_a   = r_rl_a;
        sram_d   = r_a;
        sram_wen = 1'b0;
      end
      default: ;
    endcase
  end

  // NOTE: the label SRAM is never cleared; every pixel is rewritten each run,
  // and reads outside the image are masked, so stale words cannot leak.
  // NOTE: clocked state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= IDLE;
      r_p           <= '0;
      r_rl_a        <= '0;
      r_a           <= '0;
      r_b           <= '0;
      r_conn8       <= 1'b0;
      r_label_count <= '0;
      r_overflow    <= 1'b0;
      r_busy        <= 1'b0;
      r_finish      <= 1'b0;
    end else begin
      r_finish <= 1'b0;
      case (r_state)
        IDLE: if (start) begin
          r_state       <= RD;
          r_p           <= '0;
          r_conn8       <= conn8;
          r_label_count <= '0;
          r_overflow    <= 1'b0;
          r_busy        <= 1'b1;
        end
        RD: r_state <= WR;
        WR: begin
          if (w_pix && !w_any) begin
            if (r_label_count == LBL_SAT) r_overflow    <= 1'b1;
            else                          r_label_count <= r_label_count + LABEL_W'(1);
          end
          if (w_merge) begin
            r_a     <= w_a;
            r_b     <= w_b;
            r_rl_a  <= r_p - AW'(1);
            r_state <= RL_RD;
          end
        end
        RL_RD: r_state <= RL_CMP;
        RL_CMP: begin
          if (sram_q == r_b) begin
            r_state <= RL_WR;
          end else if (r_rl_a != '0) begin
            r_rl_a  <= r_rl_a - AW'(1);
            r_state <= RL_RD;
          end
        end
        RL_WR: if (r_rl_a != '0) begin
          r_rl_a  <= r_rl_a - AW'(1);
          r_state <= RL_RD;
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
      // Leaving a pixel, either directly from WR or at the end of a pass.
      if (w_advance) begin
        if (r_p == LAST_P) begin
          r_state  <= DONE;
          r_busy   <= 1'b0;
          r_finish <= 1'b1;
        end else begin
          r_p     <= r_p + AW'(1);
          r_state <= RD;
        end
      end
    end
  end

  assign busy        = r_busy;
  assign finish      = r_finish;
  assign label_count = r_label_count;
  assign overflow    = r_overflow;

endmodule

// File: tb/tb_cle_param.sv
// Scoreboard bench for cle_param: a 32x32/8-bit instance and an 8x8/4-bit
// instance, each with its own ROM and SRAM model.
module tb_cle_param;
  import cle_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset = 1'b1;
  logic start32 = 1'b0, conn8_32 = 1'b0, start8 = 1'b0, conn8_8 = 1'b0;

  logic [6:0] rom_a32;  logic [7:0] rom_q32;
  logic [9:0] sram_a32; logic [7:0] sram_d32, sram_q32, lc32;
  logic       wen32, busy32, fin32, ovf32;

  logic [2:0] rom_a8;   logic [7:0] rom_q8;
  logic [5:0] sram_a8;  logic [3:0] sram_d8, sram_q8, lc8;
  logic       wen8, busy8, fin8, ovf8;

  logic [7:0] rom32 [128];
  logic [7:0] sram32[1024];
  logic [7:0] exp32 [1024];
  logic [7:0] rom8  [8];
  logic [3:0] sram8 [64];
  logic [3:0] exp8  [64];

  typedef struct {
    int lc;
    bit ovf;
    int cycles;  // finish cycle counted from the accepting edge; 0 = unchecked
  } exp_t;

  exp_t q32[$];
  exp_t q8[$];
  int   cyc = 0, t_start32 = 0, t_start8 = 0;
  int   n_tests = 0, n_fail = 0;

  cle_param u_d32 (
    .clk(clk), .reset(reset), .start(start32), .conn8(conn8_32),
    .rom_a(rom_a32), .rom_q(rom_q32), .sram_a(sram_a32), .sram_d(sram_d32),
    .sram_wen(wen32), .sram_q(sram_q32), .busy(busy32), .finish(fin32),
    .label_count(lc32), .overflow(ovf32)
  );

  cle_param #(.W_LOG2(3), .H_LOG2(3), .LABEL_W(4)) u_d8 (
    .clk(clk), .reset(reset), .start(start8), .conn8(conn8_8),
    .rom_a(rom_a8), .rom_q(rom_q8), .sram_a(sram_a8), .sram_d(sram_d8),
    .sram_wen(wen8), .sram_q(sram_q8), .busy(busy8), .finish(fin8),
    .label_count(lc8), .overflow(ovf8)
  );

  always @(posedge clk) cyc = cyc + 1;

  always @(posedge clk) begin
    rom_q32 <= rom32[rom_a32];
    if (!wen32) sram32[sram_a32] <= sram_d32;
    else        sram_q32 <= sram32[sram_a32];
    rom_q8 <= rom8[rom_a8];
    if (!wen8) sram8[sram_a8] <= sram_d8;
    else       sram_q8 <= sram8[sram_a8];
  end

  task automatic check(input string name, input longint act, input longint expv);
    n_tests++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  // Monitors: compare the run outcome whenever an instance pulses finish.
  always @(negedge clk) begin
    exp_t e;
    int   bad, first;
    if (fin32 === 1'b1) begin
      if (q32.size() == 0) check("d32 unexpected finish", 1, 0);
      else begin
        e = q32.pop_front();
        check("d32 label_count", lc32, e.lc);
        check("d32 overflow", ovf32, e.ovf);
        check("d32 busy at finish", busy32, 0);
        if (e.cycles > 0) check("d32 finish cycle", cyc - t_start32 + 1, e.cycles);
        bad = 0; first = 0;
        for (int i = 0; i < 1024; i++)
          if (sram32[i] !== exp32[i]) begin
            if (bad == 0) first = i;
            bad++;
          end
        if (bad != 0)
          $display("  d32 word %0d holds %0d, expected %0d", first, sram32[first], exp32[first]);
        check("d32 wrong sram words", bad, 0);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    int   bad, first;
    if (fin8 === 1'b1) begin
      if (q8.size() == 0) check("d8 unexpected finish", 1, 0);
      else begin
        e = q8.pop_front();
        check("d8 label_count", lc8, e.lc);
        check("d8 overflow", ovf8, e.ovf);
        check("d8 busy at finish", busy8, 0);
        if (e.cycles > 0) check("d8 finish cycle", cyc - t_start8 + 1, e.cycles);
        bad = 0; first = 0;
        for (int i = 0; i < 64; i++)
          if (sram8[i] !== exp8[i]) begin
            if (bad == 0) first = i;
            bad++;
          end
        if (bad != 0)
          $display("  d8 word %0d holds %0d, expected %0d", first, sram8[first], exp8[first]);
        check("d8 wrong sram words", bad, 0);
      end
    end
  end

  task automatic clear32();
    for (int i = 0; i < 128; i++)  rom32[i] = 8'h00;
    for (int i = 0; i < 1024; i++) exp32[i] = 8'h00;
  endtask

  task automatic pix32(input int r, input int c, input int lbl);
    int p;
    p = r * 32 + c;
    rom32[p >> 3][7 - (p % 8)] = 1'b1;
    exp32[p] = 8'(lbl);
  endtask

  task automatic wait_fin32();
    int n;
    n = 0;
    while (fin32 !== 1'b1 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    if (fin32 !== 1'b1) check("d32 run timeout", 0, 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic run32(input bit c8, input int lc, input bit ovf, input int cycles,
                       input bit poke_busy);
    exp_t e;
    e.lc = lc; e.ovf = ovf; e.cycles = cycles;
    q32.push_back(e);
    @(negedge clk);
    conn8_32 = c8;
    start32  = 1'b1;
    @(posedge clk);
    #1;
    t_start32 = cyc;
    start32   = 1'b0;
    if (poke_busy) begin
      repeat (100) @(negedge clk);
      conn8_32 = ~c8;
      start32  = 1'b1;
      @(negedge clk);
      start32  = 1'b0;
    end
    wait_fin32();
  endtask

  task automatic run8(input bit c8, input int lc, input bit ovf, input int cycles);
    exp_t e;
    int   n;
    e.lc = lc; e.ovf = ovf; e.cycles = cycles;
    q8.push_back(e);
    @(negedge clk);
    conn8_8 = c8;
    start8  = 1'b1;
    @(posedge clk);
    #1;
    t_start8 = cyc;
    start8   = 1'b0;
    n = 0;
    while (fin8 !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (fin8 !== 1'b1) check("d8 run timeout", 0, 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic ushape32();
    clear32();
    pix32(0, 0, 1); pix32(0, 2, 1);
    pix32(1, 0, 1); pix32(1, 1, 1); pix32(1, 2, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n, k;
    // Garbage in both SRAMs exercises masking of reads outside the image.
    for (int i = 0; i < 1024; i++) sram32[i] = 8'hFF;
    for (int i = 0; i < 64; i++)   sram8[i]  = 4'hF;
    clear32();
    for (int i = 0; i < 8; i++)  rom8[i] = 8'h00;
    for (int i = 0; i < 64; i++) exp8[i] = 4'h0;

    repeat (3) @(negedge clk);
    check("reset rom_a", rom_a32, 0);
    check("reset sram_a", sram_a32, 0);
    check("reset sram_d", sram_d32, 0);
    check("reset sram_wen", wen32, 1);
    check("reset busy", busy32, 0);
    check("reset finish", fin32, 0);
    check("reset label_count", lc32, 0);
    check("reset overflow", ovf32, 0);
    reset = 1'b0;
    @(negedge clk);

    // All-zero image; a start mid-run must be ignored. 2*32*32+1 = 2049.
    run32(1'b1, 0, 1'b0, 2049, 1'b1);

    clear32(); pix32(0, 0, 1);
    run32(1'b1, 1, 1'b0, 2049, 1'b0);

    clear32(); pix32(0, 0, 1); pix32(1, 1, 1);
    run32(1'b1, 1, 1'b0, 2049, 1'b0);

    clear32(); pix32(0, 0, 1); pix32(1, 1, 2);
    run32(1'b0, 2, 1'b0, 2049, 1'b0);

    // U-shape merge at p=34: pass over words 33..0, one match -> 33*2+3 = 69.
    ushape32();
    run32(1'b0, 2, 1'b0, 2049 + 69, 1'b0);

    // Diagonal merge through UL and UR at p=33: words 32..0 -> 32*2+3 = 67.
    clear32(); pix32(0, 0, 1); pix32(0, 2, 1); pix32(1, 1, 1);
    run32(1'b1, 2, 1'b0, 2049 + 67, 1'b0);

    // Reset while the relabel pass is writing.
    ushape32();
    @(negedge clk);
    conn8_32 = 1'b0;
    start32  = 1'b1;
    @(posedge clk);
    #1;
    start32 = 1'b0;
    n = 0;
    while (u_d32.r_state != RL_WR && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("reached RL_WR before reset", u_d32.r_state == RL_WR, 1);
    reset = 1'b1;
    @(negedge clk);
    check("state after mid-pass reset", u_d32.r_state, IDLE);
    check("busy after mid-pass reset", busy32, 0);
    check("sram_wen after mid-pass reset", wen32, 1);
    reset = 1'b0;
    @(negedge clk);
    run32(1'b0, 2, 1'b0, 2049 + 69, 1'b0);

    // 8x8 checkerboard, 4-bit labels: 32 isolated pixels saturate at 15.
    k = 0;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        if ((r + c) % 2 == 0) begin
          k++;
          rom8[r][7 - c] = 1'b1;
          exp8[r * 8 + c] = (k < 15) ? 4'(k) : 4'd15;
        end
    run8(1'b0, 15, 1'b1, 129);
    check("d8 overflow holds after finish", ovf8, 1);
    check("d8 label_count holds after finish", lc8, 15);

    // Overflow and count clear on the next start.
    for (int i = 0; i < 8; i++)  rom8[i] = 8'h00;
    for (int i = 0; i < 64; i++) exp8[i] = 4'h0;
    run8(1'b1, 0, 1'b0, 129);

    check("d32 results outstanding", q32.size(), 0);
    check("d8 results outstanding", q8.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
